// File: rtl/execute_multicycle_ctrl.sv
// Execute-stage sequencer: retires single-cycle ops or starts and tracks one long-latency unit op.
// Latency: single-cycle ops write back 1 cycle after accept; long ops write back 1 cycle after the unit's ready.
// Backpressure: issue_ready is high only in IDLE, so the core stalls while a long op is outstanding or draining.
//
// Ports:
//   clk, rst (async active-low)
//   issue_valid/issue_ready/issue_unit/issue_wren/issue_waddr/issue_wdata/issue_pc : decode -> execute handshake
//   clear                          : pipeline flush
//   unit_req/unit_ready/unit_result: start pulse, result-valid pulse and packed results per long unit
//   stall                          : inverse of issue_ready
//   fwd_wren/fwd_waddr/fwd_wdata   : combinational value that will be written back next cycle
//   wb_wren/wb_waddr/wb_wdata      : registered register-file write port (one-cycle pulse)
//   exc_valid/exc_cause/exc_pc     : watchdog exception (only with EXEC_TIMEOUT_EN)
//
// Build option: define EXEC_TIMEOUT_EN to add the long-op watchdog; otherwise long ops wait forever.
module execute_multicycle_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUNITS  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [2:0]             issue_unit,
  input  logic                   issue_wren,
  input  logic [4:0]             issue_waddr,
  input  logic [XLEN-1:0]        issue_wdata,
  input  logic [XLEN-1:0]        issue_pc,
  input  logic                   clear,
  output logic [NUNITS-1:0]      unit_req,
  input  logic [NUNITS-1:0]      unit_ready,
  input  logic [NUNITS*XLEN-1:0] unit_result,
  output logic                   stall,
  output logic                   fwd_wren,
  output logic [4:0]             fwd_waddr,
  output logic [XLEN-1:0]        fwd_wdata,
  output logic                   wb_wren,
  output logic [4:0]             wb_waddr,
  output logic [XLEN-1:0]        wb_wdata,
  output logic                   exc_valid,
  output logic [2:0]             exc_cause,
  output logic [XLEN-1:0]        exc_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_unit;
  logic [4:0]        r_waddr;
  logic              r_wren;

  logic              w_accept;
  logic              w_is_long;
  logic              w_sel_ready;
  logic [XLEN-1:0]   w_sel_result;
  logic              w_timeout;
  logic              w_exc_fire;

  logic              r_wb_wren;
  logic [4:0]        r_wb_waddr;
  logic [XLEN-1:0]   r_wb_wdata;

  assign issue_ready = (r_state == S_IDLE);
  assign stall       = ~issue_ready;
  assign w_accept    = issue_valid & issue_ready & ~clear;

  // Unit codes above NUNITS fall back to the single-cycle path.
  assign w_is_long = (issue_unit != 3'd0) && (issue_unit <= 3'(NUNITS));

  // Start pulse only exists on the accepting cycle; out-of-range codes match no bit.
  always_comb begin
    unit_req = '0;
    for (int k = 1; k <= NUNITS; k++) begin
      unit_req[k-1] = w_accept && (issue_unit == 3'(k));
    end
  end

  // Only the latched unit's ready/result are observed; the others are don't-care.
  always_comb begin
    w_sel_ready  = 1'b0;
    w_sel_result = '0;
    for (int k = 1; k <= NUNITS; k++) begin
      if (r_unit == 3'(k)) begin
        w_sel_ready  = unit_ready[k-1];
        w_sel_result = unit_result[k*XLEN-1 -: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus forwarding value; a ready in the same cycle as a timeout wins.
  always_comb begin
    w_state_nxt = r_state;
    fwd_wren    = 1'b0;
    fwd_waddr   = '0;
    fwd_wdata   = '0;
    w_exc_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_long) begin
            w_state_nxt = S_WAIT;
          end else if (issue_wren && (issue_waddr != 5'd0)) begin
            fwd_wren  = 1'b1;
            fwd_waddr = issue_waddr;
            fwd_wdata = issue_wdata;
          end
        end
      end
      S_WAIT: begin
        if (w_sel_ready) begin
          w_state_nxt = S_IDLE;
          if (!clear && r_wren && (r_waddr != 5'd0)) begin
            fwd_wren  = 1'b1;
            fwd_waddr = r_waddr;
            fwd_wdata = w_sel_result;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_exc_fire  = 1'b1;
        end else if (clear) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The flushed op's result is dropped; further clears change nothing.
        if (w_sel_ready || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_unit  <= '0;
      r_waddr <= '0;
      r_wren  <= 1'b0;
    end else if (w_accept && w_is_long) begin
      r_unit  <= issue_unit;
      r_waddr <= issue_waddr;
      r_wren  <= issue_wren;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_wren  <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
    end else begin
      r_wb_wren  <= fwd_wren;
      r_wb_waddr <= fwd_waddr;
      r_wb_wdata <= fwd_wdata;
    end
  end

  assign wb_wren  = r_wb_wren;
  assign wb_waddr = r_wb_waddr;
  assign wb_wdata = r_wb_wdata;

`ifdef EXEC_TIMEOUT_EN
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_exc_valid;
  logic [2:0]      r_exc_cause;
  logic [XLEN-1:0] r_exc_pc;

  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  // Restart on every entry into a waiting state (IDLE->WAIT and WAIT->FLUSH).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) && (w_state_nxt != S_IDLE)) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (w_accept && w_is_long) begin
      r_pc <= issue_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc_valid <= 1'b0;
      r_exc_cause <= '0;
      r_exc_pc    <= '0;
    end else begin
      r_exc_valid <= w_exc_fire;
      r_exc_cause <= w_exc_fire ? r_unit : 3'd0;
      r_exc_pc    <= w_exc_fire ? r_pc : '0;
    end
  end

  assign exc_valid = r_exc_valid;
  assign exc_cause = r_exc_cause;
  assign exc_pc    = r_exc_pc;
`else
  logic w_unused;

  // Without the watchdog the pc and limit have no consumer.
  assign w_timeout = 1'b0;
  assign w_unused  = ^{issue_pc, w_exc_fire, (TIMEOUT > 0)};
  assign exc_valid = 1'b0;
  assign exc_cause = '0;
  assign exc_pc    = '0;
`endif

endmodule

// File: tb/tb_execute_multicycle_ctrl.sv
module tb_execute_multicycle_ctrl;

  localparam int XLEN   = 32;
  localparam int NUNITS = 2;

  logic                   clk;
  logic                   rst;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [2:0]             issue_unit;
  logic                   issue_wren;
  logic [4:0]             issue_waddr;
  logic [XLEN-1:0]        issue_wdata;
  logic [XLEN-1:0]        issue_pc;
  logic                   clear;
  logic [NUNITS-1:0]      unit_req;
  logic [NUNITS-1:0]      unit_ready;
  logic [NUNITS*XLEN-1:0] unit_result;
  logic                   stall;
  logic                   fwd_wren;
  logic [4:0]             fwd_waddr;
  logic [XLEN-1:0]        fwd_wdata;
  logic                   wb_wren;
  logic [4:0]             wb_waddr;
  logic [XLEN-1:0]        wb_wdata;
  logic                   exc_valid;
  logic [2:0]             exc_cause;
  logic [XLEN-1:0]        exc_pc;

  execute_multicycle_ctrl #(
    .XLEN(XLEN), .NUNITS(NUNITS), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
    .issue_wren(issue_wren), .issue_waddr(issue_waddr), .issue_wdata(issue_wdata),
    .issue_pc(issue_pc), .clear(clear),
    .unit_req(unit_req), .unit_ready(unit_ready), .unit_result(unit_result),
    .stall(stall),
    .fwd_wren(fwd_wren), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } wb_t;

  wb_t               wb_q[$];
  logic [NUNITS-1:0] req_q[$];
  int                n_chk  = 0;
  int                n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_wb(input logic [4:0] a, input logic [XLEN-1:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    wb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] u, input logic we, input logic [4:0] a,
                       input logic [XLEN-1:0] d, input logic [XLEN-1:0] pc);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_wren  = we;
    issue_waddr = a;
    issue_wdata = d;
    issue_pc    = pc;
  endtask

  // Monitor: every writeback and every unit start pulse must match the next expectation.
  always @(negedge clk) begin
    wb_t e;
    if (wb_wren) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", wb_wren, 0);
      end else begin
        e = wb_q.pop_front();
        check("wb_waddr", wb_waddr, e.a);
        check("wb_wdata", wb_wdata, e.d);
      end
    end
    if (unit_req != '0) begin
      if (req_q.size() == 0) check("unit_req_unexpected", unit_req, 0);
      else check("unit_req", unit_req, req_q.pop_front());
    end
    if (fwd_wren) check("fwd_waddr_zero", fwd_waddr == 5'd0, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_unit  = '0;
    issue_wren  = 1'b0;
    issue_waddr = '0;
    issue_wdata = '0;
    issue_pc    = '0;
    clear       = 1'b0;
    unit_ready  = '0;
    unit_result = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_unit_req", unit_req, 0);
    check("rst_wb_wren", wb_wren, 0);
    check("rst_fwd_wren", fwd_wren, 0);
    check("rst_exc_valid", exc_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Single-cycle op, latency 1
    drive(3'd0, 1'b1, 5'd5, 32'h1234, 32'h0);
    exp_wb(5'd5, 32'h1234);
    @(negedge clk);
    check("t1_fwd_wren", fwd_wren, 1);
    check("t1_fwd_wdata", fwd_wdata, 32'h1234);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("t1_ready_after", issue_ready, 1);
    step();

    // Unit 1, ready 4 cycles after req; same-cycle and foreign readies ignored
    req_q.push_back(2'b01);
    drive(3'd1, 1'b1, 5'd7, 32'hFFFF, 32'h40);
    unit_ready  = 2'b01;
    unit_result = {32'h0, 32'h1111};
    @(negedge clk);
    check("t2_stall_issue", stall, 0);
    step();
    issue_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      unit_ready  = (i == 2) ? 2'b10 : ((i == 4) ? 2'b01 : 2'b00);
      unit_result = {32'h2222, (i == 4) ? 32'hDEAD : 32'h0};
      if (i == 4) exp_wb(5'd7, 32'hDEAD);
      @(negedge clk);
      check("t2_stall", stall, 1);
      if (i == 4) check("t2_fwd_wdata", fwd_wdata, 32'hDEAD);
      step();
    end
    unit_ready = '0;
    @(negedge clk);
    check("t2_ready_after", issue_ready, 1);
    step();

    // Unit 2, clear in WAIT -> FLUSH, second clear ignored, result dropped
    req_q.push_back(2'b10);
    drive(3'd2, 1'b1, 5'd3, 32'h0, 32'h44);
    step();
    issue_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      clear       = (i == 2) || (i == 4);
      unit_ready  = (i == 6) ? 2'b10 : 2'b00;
      unit_result = {32'hBEEF, 32'h0};
      @(negedge clk);
      check("t3_stall", stall, 1);
      if (i == 6) check("t3_fwd_wren", fwd_wren, 0);
      step();
    end
    clear      = 1'b0;
    unit_ready = '0;
    @(negedge clk);
    check("t3_ready_cycle7", issue_ready, 1);
    step();

    // waddr == 0: never forwarded or written back
    drive(3'd0, 1'b1, 5'd0, 32'hABCD, 32'h0);
    @(negedge clk);
    check("t4_fwd_single", fwd_wren, 0);
    step();
    req_q.push_back(2'b01);
    drive(3'd1, 1'b1, 5'd0, 32'h0, 32'h0);
    step();
    issue_valid = 1'b0;
    unit_ready  = 2'b01;
    unit_result = {32'h0, 32'h77};
    @(negedge clk);
    check("t4_fwd_long", fwd_wren, 0);
    step();
    unit_ready = '0;
    @(negedge clk);
    check("t4_ready_after", issue_ready, 1);
    step();

    // issue_valid together with clear drops the op
    drive(3'd1, 1'b1, 5'd4, 32'h0, 32'h0);
    clear = 1'b1;
    @(negedge clk);
    check("t5_unit_req", unit_req, 0);
    step();
    drive(3'd0, 1'b1, 5'd4, 32'h99, 32'h0);
    @(negedge clk);
    check("t5_idle", issue_ready, 1);
    check("t5_fwd_wren", fwd_wren, 0);
    step();
    issue_valid = 1'b0;
    clear       = 1'b0;
    step();

    // Out-of-range unit code behaves as single-cycle
    drive(3'd5, 1'b1, 5'd9, 32'h55, 32'h0);
    exp_wb(5'd9, 32'h55);
    @(negedge clk);
    check("t6_oor_req", unit_req, 0);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("t6_oor_ready", issue_ready, 1);
    step();

    // Back-to-back single-cycle ops
    drive(3'd0, 1'b1, 5'd1, 32'hA1, 32'h0);
    exp_wb(5'd1, 32'hA1);
    step();
    drive(3'd0, 1'b1, 5'd2, 32'hB2, 32'h0);
    exp_wb(5'd2, 32'hB2);
    step();
    issue_valid = 1'b0;
    step();

    // Reset in the middle of a long op abandons it
    req_q.push_back(2'b10);
    drive(3'd2, 1'b1, 5'd6, 32'h0, 32'h60);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("t7_busy", stall, 1);
    #1 rst = 1'b0;
    #1;
    check("t7_rst_ready", issue_ready, 1);
    check("t7_rst_wb", wb_wren, 0);
    @(posedge clk); #1;
    rst         = 1'b1;
    unit_ready  = 2'b10;
    unit_result = {32'hCAFE, 32'h0};
    step();
    unit_ready = '0;
    @(negedge clk);
    check("t7_ready_after", issue_ready, 1);
    step();

`ifdef EXEC_TIMEOUT_EN
    // Watchdog: unit 1 never answers
    begin
      int cyc;
      bit seen;
      cyc  = 1;
      seen = 1'b0;
      req_q.push_back(2'b01);
      drive(3'd1, 1'b1, 5'd8, 32'h0, 32'h80);
      step();
      issue_valid = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (exc_valid) seen = 1'b1;
        else begin
          step();
          cyc++;
        end
      end
      check("t8_exc_seen", seen, 1);
      check("t8_exc_cycle", cyc, 9);
      check("t8_exc_cause", exc_cause, 3'd1);
      check("t8_exc_pc", exc_pc, 32'h80);
      check("t8_exc_ready", issue_ready, 1);
      step();
      unit_ready  = 2'b01;
      unit_result = {32'h0, 32'h808};
      @(negedge clk);
      check("t8_exc_pulse", exc_valid, 0);
      step();
      unit_ready = '0;
      drive(3'd0, 1'b1, 5'd10, 32'h10, 32'h0);
      exp_wb(5'd10, 32'h10);
      step();
      issue_valid = 1'b0;
      step();
    end
`else
    // No watchdog: a silent unit keeps the stage busy indefinitely
    begin
      int exc_seen;
      int idle_seen;
      exc_seen  = 0;
      idle_seen = 0;
      req_q.push_back(2'b01);
      drive(3'd1, 1'b1, 5'd8, 32'h0, 32'h80);
      step();
      issue_valid = 1'b0;
      repeat (70) begin
        @(negedge clk);
        if (exc_valid) exc_seen++;
        if (!stall) idle_seen++;
        step();
      end
      check("t8_no_exc", exc_seen, 0);
      check("t8_still_busy", idle_seen, 0);
      unit_ready  = 2'b01;
      unit_result = {32'h0, 32'h808};
      exp_wb(5'd8, 32'h808);
      step();
      unit_ready = '0;
      @(negedge clk);
      check("t8_ready_after", issue_ready, 1);
      step();
    end
`endif

    step();
    step();
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
